// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//   Parametrised multi-port register file for the pipelined CPU datapath.
//   Depth is 2**ABITS words of WIDTH bits. It has NRD independent read ports
//   and NWR (1 or 2) write ports. On a write collision the higher-numbered
//   port wins. Options:
//     - a hard-wired zero register (ZERO_EN / ZERO_IDX);
//     - same-cycle write-to-read forwarding (BYPASS);
//     - an optional registered read stage with one cycle of latency (RD_REG).
//   A synchronous reset clears every word and the registered read data.
//
// Ports
//   clk    in   1          rising-edge clock for all state
//   reset  in   1          synchronous, active-high clear
//   we     in   NWR        per-port write enable
//   waddr  in   NWR*ABITS  write address, port p at [p*ABITS +: ABITS]
//   wdata  in   NWR*WIDTH  write data,    port p at [p*WIDTH +: WIDTH]
//   raddr  in   NRD*ABITS  read address,  port r at [r*ABITS +: ABITS]
//   rdata  out  NRD*WIDTH  read data,     port r at [r*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int WIDTH    = 64,
    parameter int ABITS    = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*ABITS-1:0] waddr,
    input  logic [NWR*WIDTH-1:0] wdata,
    input  logic [NRD*ABITS-1:0] raddr,
    output logic [NRD*WIDTH-1:0] rdata
);

    localparam int               DEPTH     = 1 << ABITS;
    localparam logic [ABITS-1:0] ZERO_ADDR = ABITS'(ZERO_IDX);
    localparam bit               ZERO_ON   = (ZERO_EN != 0);
    localparam bit               BYP_ON    = (BYPASS != 0);
    localparam bit               RDREG_ON  = (RD_REG != 0);

    logic [WIDTH-1:0]     mem_q   [DEPTH];
    logic [WIDTH-1:0]     mem_d   [DEPTH];

    logic [ABITS-1:0]     waddr_s [NWR];
    logic [WIDTH-1:0]     wdata_s [NWR];
    logic                 wr_en_s [NWR];
    logic [ABITS-1:0]     raddr_s [NRD];

    logic                 byp_hit_s  [NRD];
    logic [WIDTH-1:0]     byp_data_s [NRD];
    logic [WIDTH-1:0]     rd_val_s   [NRD];
    logic [NRD*WIDTH-1:0] rd_val_packed_s;
    logic [NRD*WIDTH-1:0] rdata_d;
    logic [NRD*WIDTH-1:0] rdata_q;

    // Split the flat write buses into per-port fields.
    // A write aimed at the zero register never reaches storage.
    for (genvar p = 0; p < NWR; p++) begin : g_wr
        assign waddr_s[p] = waddr[p*ABITS +: ABITS];
        assign wdata_s[p] = wdata[p*WIDTH +: WIDTH];
        assign wr_en_s[p] = we[p] & ~(ZERO_ON & (waddr_s[p] == ZERO_ADDR));
    end

    // Split the flat read buses into per-port fields and repack the read values
    for (genvar r = 0; r < NRD; r++) begin : g_rd
        assign raddr_s[r]                       = raddr[r*ABITS +: ABITS];
        assign rd_val_packed_s[r*WIDTH +: WIDTH] = rd_val_s[r];
    end

    // Next storage image: ports are applied in ascending order so a
    // higher-numbered port overrides a lower one on the same address
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            for (int p = 0; p < NWR; p++) begin
                mem_d[i] = (wr_en_s[p] && (waddr_s[p] == ABITS'(i))) ? wdata_s[p] : mem_d[i];
            end
        end
    end

    // Storage update with synchronous clear; writes in a reset cycle are lost
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read value per port: zero register first, then forwarded write data
    // (highest-numbered matching port), then stored contents. Forwarding is
    // suppressed during reset so the read follows the stored words.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            byp_hit_s[r]  = 1'b0;
            byp_data_s[r] = '0;
            for (int p = 0; p < NWR; p++) begin
                byp_data_s[r] = (we[p] && (waddr_s[p] == raddr_s[r])) ? wdata_s[p] : byp_data_s[r];
                byp_hit_s[r]  = byp_hit_s[r] | (we[p] && (waddr_s[p] == raddr_s[r]));
            end
            rd_val_s[r] = (ZERO_ON && (raddr_s[r] == ZERO_ADDR)) ? '0 :
                          (BYP_ON && !reset && byp_hit_s[r])    ? byp_data_s[r] :
                                                                   mem_q[raddr_s[r]];
        end
    end

    // Next value of the registered read stage
    always_comb begin
        rdata_d = reset ? '0 : rd_val_packed_s;
    end

    // Registered read stage; only drives rdata when RD_REG is set
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = RDREG_ON ? rdata_q : rd_val_packed_s;

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port register file, the successor to the fixed 32×64, 2-read/1-write file in the datapath. Adds configurable width, depth, read-port count and a second write port with defined collision priority. Also adds write-to-read bypass, an optional registered read stage, a configurable hard-wired zero register, and synchronous clear on reset. It sits between decode (register addresses) and execute/writeback (operands, results) in the pipelined CPU.

## Interface
- WIDTH, 64: bits per register
- ABITS, 5: address bits; depth = 2**ABITS
- NRD, 2: number of read ports
- NWR, 2: number of write ports (1 or 2)
- ZERO_EN, 1: 1 = register ZERO_IDX always reads 0 and ignores writes
- ZERO_IDX, 31: index of hard-wired zero register
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads
- RD_REG, 0: 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and read outputs
- we  in  NWR  per-port write enable
- waddr  in  NWR*ABITS  write addresses; port p occupies bits [p*ABITS +: ABITS]
- wdata  in  NWR*WIDTH  write data; port p occupies bits [p*WIDTH +: WIDTH]
- raddr  in  NRD*ABITS  read addresses; port r occupies bits [r*ABITS +: ABITS]
- rdata  out  NRD*WIDTH  read data; port r occupies bits [r*WIDTH +: WIDTH]

## Operation
- Storage: 2**ABITS words × WIDTH bits; all words 0 after reset.
- Write: at a rising edge with reset=0, for each p with we[p]=1: mem[waddr[p]] <= wdata[p].
- Write collision, both ports enabled to the same address: higher-numbered port (port 1) wins; the other write is dropped.
- Zero register (ZERO_EN=1): writes to ZERO_IDX are discarded; reads of ZERO_IDX return 0 regardless of bypass.
- Read value v(r), priority high to low:
  - 0 if ZERO_EN and raddr[r]==ZERO_IDX
  - if BYPASS: wdata of highest-numbered port p with we[p]=1 and waddr[p]==raddr[r]
  - otherwise mem[raddr[r]]
- Bypass is suppressed while reset=1; v(r) then follows the stored contents.
- RD_REG=0: rdata[r] = v(r), combinational.
- RD_REG=1: rdata[r] <= v(r) at each rising edge; rdata <= 0 when reset=1.
- Read ports are independent. Any number may address the same register.
- Out-of-range addresses cannot occur (depth = 2**ABITS).

## Timing
- Reset: takes effect at the first rising edge with reset=1. Writes in that cycle are dropped. After that edge, all words are 0 and rdata is 0 (both RD_REG modes).
- Write latency: new data is in mem after the enabling edge.
- RD_REG=0, BYPASS=0: a read of the written address shows the new value in the cycle after the edge.
- RD_REG=0, BYPASS=1: new value visible combinationally in the same cycle we is asserted.
- RD_REG=1, BYPASS=1: raddr presented in cycle N yields, after edge N, data including any cycle-N write to that address.
- RD_REG=1, BYPASS=0: same, but a cycle-N write is not included; rdata shows the old value.
- No stalls or handshakes; one write per port per cycle; reads unconstrained.
- Reset mid-stream: all previous contents are lost. The first post-reset write behaves normally.

## Test plan
- Reset then read all 32 addresses on both ports -> every rdata = 0 (RD_REG=0 and 1 builds).
- Write i*64'h0000010204080001 to regs 0–30 via port 0, then read back with raddr0=i-1, raddr1=i -> exact pattern returned; reg 31 reads 0.
- we=2'b11, waddr0=waddr1=5, wdata0=64'hAAAA, wdata1=64'h5555 -> reg 5 = 64'h5555 next cycle; with BYPASS=1 a same-cycle read of 5 returns 64'h5555.
- Write 64'hA0 to reg 31 on either port with bypass on -> read of 31 returns 0 in the same cycle and every later cycle.
- BYPASS=0, RD_REG=0: write 64'h1234 to reg 7 while reading 7 -> old value this cycle, 64'h1234 next cycle.
- Reg 3 = 64'hFF; assert reset together with we=1, waddr=3, wdata=64'h77 -> after the edge reg 3 = 0 and rdata = 0; write 64'h77 after reset deasserts -> reads 64'h77.
